// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//
// Multi-channel clock divider for the board clock block. Every channel
// produces a registered 50% duty divided clock plus a one-cycle tick strobe
// that marks the cycle in which its divided clock goes 0->1. That strobe lets
// logic stay in the clk_board domain. Channel 0 is the CPU clock. It can be
// stopped cleanly at low level and single-stepped one period at a time.
// Every channel's half-period can be rewritten at run time.
//
// Build option:
//   CLK_STEP_EN  defined   : STEP state and step edge detector are built.
//                undefined : the step port exists but is ignored. HALT only
//                            exits when stop is released.
//
// Parameters:
//   CHANNELS      number of divided outputs (>= 1)
//   CNT_W         width of half-period registers and counters
//   DEFAULT_HALF  packed reset half-periods, channel k at [k*CNT_W +: CNT_W]
//
// Ports:
//   clk_board  in   board clock, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   stop       in   level, request halt of channel 0
//   step       in   level, rising edge requests one CPU period while halted
//   cfg_we     in   one-cycle half-period write strobe
//   cfg_ch     in   channel addressed by cfg_we (out-of-range writes ignored)
//   cfg_half   in   new half-period in clk_board cycles (0 behaves as 1)
//   clk_out    out  divided clocks, registered
//   tick       out  one-cycle strobe coincident with clk_out[k] rising
//   halted     out  high while channel 0 sits in HALT
//
// Channel 0 states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_RUN   | free running
//   S_DRAIN | stop requested while clk_out[0] high; run until it falls
//   S_HALT  | counter and clk_out[0] frozen low, halted=1
//   S_STEP  | one full period (rise then fall) out of HALT, then back
// -----------------------------------------------------------------------------
module clk_div_gen #(
    parameter int CHANNELS = 2,
    parameter int CNT_W = 32,
    parameter logic [CHANNELS*CNT_W-1:0] DEFAULT_HALF = {32'd50000, 32'd5000000},
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_board,
    input  logic                rst_n,
    input  logic                stop,
    input  logic                step,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic                halted
);

`ifdef CLK_STEP_EN
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]    half_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    eff_half [CHANNELS];
    logic [CHANNELS-1:0] clk_q;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] at_tc;
    logic [CHANNELS-1:0] cnt_en;

    logic run0;       // channel 0 counter advances this cycle
    logic cnt0_clr;   // channel 0 counter restarts at entry to STEP
    logic fall0;      // channel 0 falls this cycle, given it is counting

    // ------------------------------------------------------------------
    // Per-channel decode: terminal count and write-address hit.
    // A programmed half-period of 0 is treated as 1 so the output never
    // stalls and never divides by zero.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            eff_half[k] = (half_q[k] == '0) ? CNT_W'(1) : half_q[k];
            at_tc[k]    = (cnt_q[k] == eff_half[k] - CNT_W'(1));
            wr_hit[k]   = cfg_we && (cfg_ch == CH_W'(k));
        end
    end

    always_comb begin
        cnt_en    = '1;
        cnt_en[0] = run0;
    end

    // A write in the same cycle suppresses the toggle, so it cannot end a
    // DRAIN or STEP either.
    assign fall0 = at_tc[0] & ~wr_hit[0] & clk_q[0];

    // ------------------------------------------------------------------
    // Step edge detector. It samples every cycle, so edges seen outside
    // HALT are consumed and never queued.
    // ------------------------------------------------------------------
`ifdef CLK_STEP_EN
    logic step_q;
    logic step_rise;

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
`else
    logic unused_step;
    assign unused_step = step;
`endif

    // ------------------------------------------------------------------
    // Channel 0 control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run0     = 1'b1;
        cnt0_clr = 1'b0;
        case (state_q)
            S_RUN: begin
                if (stop) begin
                    if (clk_q[0]) begin
                        // Let the high phase finish at full length.
                        state_d = S_DRAIN;
                    end else begin
                        // Already low: freeze here so no new high phase starts.
                        state_d = S_HALT;
                        run0    = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (!stop) begin
                    state_d = S_RUN;
                end else if (fall0) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                run0 = 1'b0;
                if (!stop) begin
                    state_d = S_RUN;
`ifdef CLK_STEP_EN
                end else if (step_rise) begin
                    // Restart from zero so the stepped period is a full one.
                    state_d  = S_STEP;
                    cnt0_clr = 1'b1;
`endif
                end
            end
`ifdef CLK_STEP_EN
            S_STEP: begin
                // stop is not looked at here; the period always completes.
                if (fall0) begin
                    state_d = S_HALT;
                end
            end
`endif
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, half-period registers and output flops.
    // A config write takes priority over counting for its channel.
    // Its output level is held, and the new half-period applies from
    // the next cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                half_q[k] <= DEFAULT_HALF[k*CNT_W +: CNT_W];
                cnt_q[k]  <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                tick_q[k] <= 1'b0;
                if (wr_hit[k]) begin
                    half_q[k] <= cfg_half;
                    cnt_q[k]  <= '0;
                end else if ((k == 0) && cnt0_clr) begin
                    cnt_q[k] <= '0;
                end else if (cnt_en[k]) begin
                    if (at_tc[k]) begin
                        cnt_q[k]  <= '0;
                        clk_q[k]  <= ~clk_q[k];
                        tick_q[k] <= ~clk_q[k];
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
//
// Directed bench for clk_div_gen with three channels, half-periods 2/3/4.
// Cycle c is the c-th rising edge of clk_board after rst_n is released.
// Outputs are sampled 1 time unit after that edge. Expected waveforms are
// hand-derived bit tables indexed by cycle.
// -----------------------------------------------------------------------------
module tb_clk_div_gen;

    localparam int CHANNELS = 3;
    localparam int CNT_W    = 32;
    localparam int CH_W     = 2;

    logic                clk_board = 1'b0;
    logic                rst_n     = 1'b0;
    logic                stop      = 1'b0;
    logic                step      = 1'b0;
    logic                cfg_we    = 1'b0;
    logic [CH_W-1:0]     cfg_ch    = '0;
    logic [CNT_W-1:0]    cfg_half  = '0;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;
    logic                halted;

    int n_vec = 0;
    int n_err = 0;

    // Free-run waveforms, bit c = level after cycle c (half 2, 3, 4).
    logic [12:1] e_c0 = 12'b011001100110;
    logic [12:1] e_t0 = 12'b001000100010;
    logic [12:1] e_c1 = 12'b011100011100;
    logic [12:1] e_t1 = 12'b000100000100;
    logic [12:1] e_c2 = 12'b100001111000;
    logic [12:1] e_t2 = 12'b100000001000;

    // Step scenario, bit i = level after the i-th edge counted from the step edge.
`ifdef CLK_STEP_EN
    logic [6:0] e_sh = 7'b1110000;
    logic [6:0] e_sc = 7'b0001100;
    logic [6:0] e_st = 7'b0000100;
`else
    logic [6:0] e_sh = 7'b1111111;
    logic [6:0] e_sc = 7'b0000000;
    logic [6:0] e_st = 7'b0000000;
`endif

    clk_div_gen #(
        .CHANNELS     (CHANNELS),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF ({32'd4, 32'd3, 32'd2})
    ) dut (
        .clk_board (clk_board),
        .rst_n     (rst_n),
        .stop      (stop),
        .step      (step),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick),
        .halted    (halted)
    );

    always #5 clk_board = ~clk_board;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk_board);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk_board);
        rst_n = 1'b0;
        @(negedge clk_board);
        @(negedge clk_board);
        rst_n = 1'b1;
    endtask

    // ch1_fast: channel 1 reprogrammed to toggle every cycle from cycle 2.
    task automatic check_free(input int c, input string sc, input bit ch1_fast);
        logic ec1;
        logic et1;
        if (ch1_fast) begin
            ec1 = (c % 2 == 0);
            et1 = (c % 2 == 0);
        end else begin
            ec1 = e_c1[c];
            et1 = e_t1[c];
        end
        chk($sformatf("%s c%0d clk0", sc, c), clk_out[0], e_c0[c]);
        chk($sformatf("%s c%0d tick0", sc, c), tick[0], e_t0[c]);
        chk($sformatf("%s c%0d clk1", sc, c), clk_out[1], ec1);
        chk($sformatf("%s c%0d tick1", sc, c), tick[1], et1);
        chk($sformatf("%s c%0d clk2", sc, c), clk_out[2], e_c2[c]);
        chk($sformatf("%s c%0d tick2", sc, c), tick[2], e_t2[c]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        chk("reset clk_out", clk_out, 3'b000);
        chk("reset tick", tick, 3'b000);
        chk("reset halted", halted, 1'b0);
        @(negedge clk_board);
        rst_n = 1'b1;

        // Free run
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check_free(c, "run", 1'b0);
        end

        // Stop while clk_out0 high: drain, halt, release
        reset_dut();
        cyc();
        check_free(1, "stop", 1'b0);
        cyc();
        check_free(2, "stop", 1'b0);
        stop = 1'b1;
        cyc();
        chk("drain c3 clk0", clk_out[0], 1'b1);
        chk("drain c3 halted", halted, 1'b0);
        cyc();
        chk("drain c4 clk0", clk_out[0], 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("halt %0d clk0", i), clk_out[0], 1'b0);
            chk($sformatf("halt %0d halted", i), halted, 1'b1);
            chk($sformatf("halt %0d tick0", i), tick[0], 1'b0);
        end
        stop = 1'b0;
        cyc();
        chk("resume e0 halted", halted, 1'b0);
        chk("resume e0 clk0", clk_out[0], 1'b0);
        cyc();
        chk("resume e1 clk0", clk_out[0], 1'b0);
        cyc();
        chk("resume e2 clk0", clk_out[0], 1'b1);
        chk("resume e2 tick0", tick[0], 1'b1);

        // Single step from HALT, second pulse during STEP ignored
        stop = 1'b1;
        reset_dut();
        cyc();
        chk("pre-step halted", halted, 1'b1);
        chk("pre-step clk0", clk_out[0], 1'b0);
        step = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            cyc();
            chk($sformatf("step %0d halted", i), halted, e_sh[i]);
            chk($sformatf("step %0d clk0", i), clk_out[0], e_sc[i]);
            chk($sformatf("step %0d tick0", i), tick[0], e_st[i]);
            if (i == 0) step = 1'b0;
            if (i == 1) step = 1'b1;
            if (i == 2) step = 1'b0;
        end
        stop = 1'b0;
        cyc();
        chk("step exit halted", halted, 1'b0);

        // Reprogram channel 1 to half=1, then half=0
        cfg_we   = 1'b1;
        cfg_ch   = 2'd1;
        cfg_half = 32'd1;
        reset_dut();
        cyc();
        cfg_we = 1'b0;
        check_free(1, "half1", 1'b1);
        for (int c = 2; c <= 8; c++) begin
            cyc();
            check_free(c, "half1", 1'b1);
        end

        cfg_we   = 1'b1;
        cfg_ch   = 2'd1;
        cfg_half = 32'd0;
        reset_dut();
        cyc();
        cfg_we = 1'b0;
        check_free(1, "half0", 1'b1);
        for (int c = 2; c <= 8; c++) begin
            cyc();
            check_free(c, "half0", 1'b1);
        end
        // Out-of-range channel write changes nothing
        cfg_we   = 1'b1;
        cfg_ch   = 2'd3;
        cfg_half = 32'd7;
        cyc();
        cfg_we = 1'b0;
        check_free(9, "badch", 1'b1);
        for (int c = 10; c <= 12; c++) begin
            cyc();
            check_free(c, "badch", 1'b1);
        end

        // Asynchronous reset while clk_out0 is high
`ifdef CLK_STEP_EN
        stop = 1'b1;
        reset_dut();
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
`else
        stop = 1'b0;
        reset_dut();
        cyc();
        cyc();
`endif
        chk("pre-areset clk0", clk_out[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset clk_out", clk_out, 3'b000);
        chk("areset tick", tick, 3'b000);
        chk("areset halted", halted, 1'b0);
        stop = 1'b0;
        step = 1'b0;
        @(negedge clk_board);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check_free(c, "post", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
